mc_control_fsm: RTL and testbench

- Multicycle sequencer for the RV32I core subset: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, bne, jal, lui.
- Replaces the single-cycle control path. Drives PC, IR, register-file and memory enables and the datapath mux selects, one state per cycle.
- Datapath shares one memory/peripheral port between fetch and data access, so memory access waits on mem_ready.

---
 rtl/mc_control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle control sequencer for an RV32I subset
// (add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, bne, jal, lui).
//
// One state per cycle drives the PC/IR/register-file/memory enables and the
// datapath mux selects. Fetch and data access share a single memory port, so
// FETCH, MEMREAD and MEMWRITE stall until mem_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   op, funct3, funct7_5  instruction fields IR[6:0], IR[14:12], IR[30]
//   zero                ALU zero flag (branch compare)
//   mem_ready           memory/peripheral access completes this cycle
//   pc_write, ir_write  PC load enable, IR/OldPC load enable
//   adr_src             memory address select: 0=PC, 1=ALUOut
//   mem_write, reg_write  store strobe, register-file write enable
//   result_src          00=ALUOut 01=Data 10=ALUResult 11=ImmExt
//   alu_src_a           00=PC 01=OldPC 10=A register
//   alu_src_b           00=WriteData 01=ImmExt 10=constant 4
//   alu_control         000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src             000 I, 001 S, 010 B, 011 J, 100 U
//   illegal             one-cycle pulse in DECODE on an unsupported opcode
//   state               current state, for debug
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  assign state = state_reg;

  // ALU operation from funct3; allow_sub is only set for R-type, since
  // IR[30] is part of the immediate for I-type arithmetic.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                            input logic       allow_sub);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = allow_sub ? 3'b001 : 3'b000;
      3'b010:  ctl = 3'b101;
      3'b110:  ctl = 3'b011;
      3'b111:  ctl = 3'b010;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    illegal     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC as the IR loads.
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC+imm so BRANCH/JAL find their target in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held for the whole access, not just the completing cycle.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decode(funct3, funct7_5);
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decode(funct3, 1'b0);
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: pc_write = 1'b0;
        endcase
        state_next = S_FETCH;
      end
      S_JAL: begin
        // ALU forms OldPC+4 (link value) while the PC loads the target.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset holds the register in FETCH; also suppress FETCH's mem_ready
    // driven enables so nothing is written while rst is high.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal;
  logic [3:0] state;

  int vectors;
  int miscompares;

  mc_control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // 2 units later, well before the next edge.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    op        = 7'b0100011;
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want 0", state);
    end
    vectors++;
    if ({pc_write, ir_write, mem_write, reg_write, illegal} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_enables: got pc=%b ir=%b mw=%b rw=%b il=%b want all 0",
               pc_write, ir_write, mem_write, reg_write, illegal);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({ir_write, pc_write} !== 2'b11) begin
      miscompares++;
      $display("FAIL release_fetch: got ir=%b pc=%b want 1 1", ir_write, pc_write);
    end
    advance();          // DECODE
    advance();          // MEMADR
    mem_ready = 1'b0;
    advance();          // MEMWRITE, stalled
    #2;
    vectors++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_store: got state=%0d mw=%b want 5 1", state, mem_write);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (state !== 4'd0 || {pc_write, ir_write, mem_write, reg_write} !== 4'b0) begin
      miscompares++;
      $display("FAIL midinstr_reset: got state=%0d pc=%b ir=%b mw=%b rw=%b want 0 0 0 0 0",
               state, pc_write, ir_write, mem_write, reg_write);
    end
    rst = 1'b0;
    advance();          // FETCH holds while mem_ready=0
    #1;
    vectors++;
    if (state !== 4'd0 || ir_write !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_stall: got state=%0d ir=%b want 0 0", state, ir_write);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_st [0:7];
    logic       mr     [0:7];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #2;
      vectors++;
      if (state !== exp_st[i]) begin
        miscompares++;
        $display("FAIL load_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      vectors++;
      if (reg_write !== (exp_st[i] == 4'd4) || mem_write !== 1'b0) begin
        miscompares++;
        $display("FAIL load_writes[%0d]: got rw=%b mw=%b want %b 0", i, reg_write, mem_write,
                 exp_st[i] == 4'd4);
      end
      vectors++;
      if (ir_write !== (exp_st[i] == 4'd0 && mr[i])) begin
        miscompares++;
        $display("FAIL load_irw[%0d]: got %b want %b", i, ir_write, exp_st[i] == 4'd0 && mr[i]);
      end
      if (exp_st[i] == 4'd4) begin
        vectors++;
        if (result_src !== 2'b01) begin
          miscompares++;
          $display("FAIL load_result_src: got %b want 01", result_src);
        end
      end
      if (exp_st[i] == 4'd3) begin
        vectors++;
        if (adr_src !== 1'b1) begin
          miscompares++;
          $display("FAIL load_adr_src[%0d]: got %b want 1", i, adr_src);
        end
      end
      if (i < 7) advance();
    end
  endtask

  task automatic test_store_wait();
    logic [3:0] exp_st [0:7];
    logic       mr     [0:7];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #2;
      vectors++;
      if (state !== exp_st[i]) begin
        miscompares++;
        $display("FAIL store_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      vectors++;
      if (mem_write !== (exp_st[i] == 4'd5) || reg_write !== 1'b0) begin
        miscompares++;
        $display("FAIL store_writes[%0d]: got mw=%b rw=%b want %b 0", i, mem_write, reg_write,
                 exp_st[i] == 4'd5);
      end
      vectors++;
      if (imm_src !== 3'b001) begin
        miscompares++;
        $display("FAIL store_imm_src[%0d]: got %b want 001", i, imm_src);
      end
      if (i < 7) advance();
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops  [0:4];
    logic [2:0] f3s  [0:4];
    logic       f7s  [0:4];
    logic [3:0] exs  [0:4];
    logic [2:0] alus [0:4];
    logic [3:0] exp_st;
    ops  = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011};
    f3s  = '{3'b000, 3'b111, 3'b000, 3'b010, 3'b110};
    f7s  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exs  = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd6};
    alus = '{3'b001, 3'b010, 3'b000, 3'b101, 3'b011};
    mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      op = ops[c]; funct3 = f3s[c]; funct7_5 = f7s[c];
      for (int i = 0; i < 5; i++) begin
        exp_st = (i == 2) ? exs[c] : (i == 3) ? 4'd8 : (i == 1) ? 4'd1 : 4'd0;
        #2;
        vectors++;
        if (state !== exp_st) begin
          miscompares++;
          $display("FAIL alu_state[%0d.%0d]: got %0d want %0d", c, i, state, exp_st);
        end
        if (i == 2) begin
          vectors++;
          if (alu_control !== alus[c]) begin
            miscompares++;
            $display("FAIL alu_control[%0d]: got %b want %b", c, alu_control, alus[c]);
          end
        end
        if (i == 3) begin
          vectors++;
          if (reg_write !== 1'b1 || result_src !== 2'b00) begin
            miscompares++;
            $display("FAIL alu_wb[%0d]: got rw=%b rs=%b want 1 00", c, reg_write, result_src);
          end
        end
        if (i < 4) advance();
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [0:4];
    logic       zs  [0:4];
    logic       pcs [0:4];
    logic [3:0] exp_st;
    f3s = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pcs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    op = 7'b1100011; funct7_5 = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      funct3 = f3s[c]; zero = zs[c];
      for (int i = 0; i < 4; i++) begin
        exp_st = (i == 2) ? 4'd9 : (i == 1) ? 4'd1 : 4'd0;
        #2;
        vectors++;
        if (state !== exp_st) begin
          miscompares++;
          $display("FAIL br_state[%0d.%0d]: got %0d want %0d", c, i, state, exp_st);
        end
        if (i == 2) begin
          vectors++;
          if (pc_write !== pcs[c]) begin
            miscompares++;
            $display("FAIL br_pc_write[%0d]: got %b want %b", c, pc_write, pcs[c]);
          end
          vectors++;
          if (alu_control !== 3'b001 || alu_src_a !== 2'b10 || imm_src !== 3'b010) begin
            miscompares++;
            $display("FAIL br_ctl[%0d]: got alu=%b a=%b imm=%b want 001 10 010",
                     c, alu_control, alu_src_a, imm_src);
          end
        end
        if (i < 3) advance();
      end
    end
  endtask

  task automatic test_jal();
    logic [3:0] exp_st [0:4];
    exp_st = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    op = 7'b1101111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      vectors++;
      if (state !== exp_st[i]) begin
        miscompares++;
        $display("FAIL jal_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 1) begin
        vectors++;
        if (alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || pc_write !== 1'b0) begin
          miscompares++;
          $display("FAIL decode_ctl: got a=%b b=%b pc=%b want 01 01 0", alu_src_a, alu_src_b, pc_write);
        end
      end
      if (i == 2) begin
        vectors++;
        if (pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || reg_write !== 1'b0) begin
          miscompares++;
          $display("FAIL jal_ctl: got pc=%b a=%b b=%b rw=%b want 1 01 10 0",
                   pc_write, alu_src_a, alu_src_b, reg_write);
        end
      end
      if (i == 3) begin
        vectors++;
        if (reg_write !== 1'b1) begin
          miscompares++;
          $display("FAIL jal_link: got rw=%b want 1", reg_write);
        end
      end
      if (i < 4) advance();
    end
  endtask

  task automatic test_lui();
    logic [3:0] exp_st [0:3];
    exp_st = '{4'd0, 4'd1, 4'd11, 4'd0};
    op = 7'b0110111; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      vectors++;
      if (state !== exp_st[i]) begin
        miscompares++;
        $display("FAIL lui_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        vectors++;
        if (result_src !== 2'b11 || reg_write !== 1'b1 || imm_src !== 3'b100) begin
          miscompares++;
          $display("FAIL lui_ctl: got rs=%b rw=%b imm=%b want 11 1 100", result_src, reg_write, imm_src);
        end
      end
      if (i < 3) advance();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] exp_st [0:2];
    exp_st = '{4'd0, 4'd1, 4'd0};
    op = 7'b1111111; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if (state !== exp_st[i]) begin
        miscompares++;
        $display("FAIL ill_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      vectors++;
      if (illegal !== (i == 1)) begin
        miscompares++;
        $display("FAIL ill_pulse[%0d]: got %b want %b", i, illegal, i == 1);
      end
      vectors++;
      if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
        miscompares++;
        $display("FAIL ill_writes[%0d]: got rw=%b mw=%b want 0 0", i, reg_write, mem_write);
      end
      if (i < 2) advance();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    op          = 7'b0;
    funct3      = 3'b0;
    funct7_5    = 1'b0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_store_wait();
    test_alu_decode();
    test_branch();
    test_jal();
    test_lui();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
